cnn_param: RTL and testbench

CNN_PARAM -- requirements
Module: cnn_param

---
 rtl/cnn_param.sv | 130 +++++++++++++
 tb/tb_cnn_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_param.sv
// cnn_param: streaming single-channel convolution with ReLU and 2x2 max/average pooling
module cnn_param #(
    parameter  int IMG = 6,
    parameter  int KER = 3,
    parameter  int DW  = 8,
    localparam int F   = IMG - KER + 1,
    localparam int P   = F / 2,
    localparam int OW  = 2 * DW + $clog2(KER * KER)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic [1:0]           opt,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data
);
    localparam int IW = $clog2(IMG * IMG);
    localparam int KW = KER > 1 ? $clog2(KER) : 1;
    localparam int PW = P > 1 ? $clog2(P) : 1;
    localparam int FW = $clog2(F * F);
    localparam int SW = OW + 2;

    typedef enum logic [2:0] {IDLE, LOAD_IMG, LOAD_KER, FINISH, OUT} state_t;

    state_t st, nxt;
    logic signed [DW-1:0] img [IMG*IMG];
    logic signed [OW-1:0] feat [F*F];
    logic [IW-1:0] pix, koff;
    logic [KW-1:0] kx, ky;
    logic [PW-1:0] ox, oy;
    logic [1:0] opt_q;
    logic acc, last_pix, last_w, last_o;
    logic [FW-1:0] fb;
    logic signed [OW-1:0] q0, q1, q2, q3, m01, m23, mx, pooled;
    logic signed [SW-1:0] sum;

    assign acc      = in_valid && in_ready;
    assign last_pix = pix == IW'(IMG * IMG - 1);
    assign last_w   = kx == KW'(KER - 1) && ky == KW'(KER - 1);
    assign last_o   = ox == PW'(P - 1) && oy == PW'(P - 1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= nxt;
    end

    // next-state: loads advance only on accepted beats, output phase runs P*P cycles
    always_comb begin
        nxt = (st == IDLE && acc)                 ? LOAD_IMG :
              (st == LOAD_IMG && acc && last_pix) ? LOAD_KER :
              (st == LOAD_KER && acc && last_w)   ? FINISH   :
              (st == FINISH)                      ? OUT      :
              (st == OUT && last_o)               ? IDLE     : st;
    end

    // handshake and result outputs decoded from state
    always_comb begin
        in_ready  = st == IDLE || st == LOAD_IMG || st == LOAD_KER;
        out_valid = st == OUT;
        out_data  = out_valid ? pooled : '0;
    end

    // pixel, kernel-offset and output counters; everything restarts on the first beat of a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix   <= '0;
            koff  <= '0;
            kx    <= '0;
            ky    <= '0;
            ox    <= '0;
            oy    <= '0;
            opt_q <= '0;
        end else begin
            if (acc && st == IDLE) begin
                pix   <= IW'(1);
                opt_q <= opt;
                koff  <= '0;
                kx    <= '0;
                ky    <= '0;
                ox    <= '0;
                oy    <= '0;
            end
            if (acc && st == LOAD_IMG) pix <= pix + 1'b1;
            if (acc && st == LOAD_KER) begin
                kx   <= kx == KW'(KER - 1) ? '0 : kx + 1'b1;
                ky   <= kx == KW'(KER - 1) ? ky + 1'b1 : ky;
                koff <= koff + (kx == KW'(KER - 1) ? IW'(IMG - KER + 1) : IW'(1));
            end
            if (st == OUT) begin
                ox <= ox == PW'(P - 1) ? '0 : ox + 1'b1;
                oy <= ox == PW'(P - 1) ? oy + 1'b1 : oy;
            end
        end
    end

    // image store, row-major by accepted pixel index
    always_ff @(posedge clk) begin
        if (acc && (st == IDLE || st == LOAD_IMG)) img[st == IDLE ? '0 : pix] <= in_data;
    end

    // every feature cell accumulates weight * image pixel at its window offset koff
    for (genvar i = 0; i < F; i++) begin : g_row
        for (genvar j = 0; j < F; j++) begin : g_col
            logic signed [OW-1:0] prod;
            assign prod = OW'(in_data) * OW'(img[koff + IW'(i * IMG + j)]);
            // clear at frame start, accumulate on each accepted weight
            always_ff @(posedge clk) begin
                if (acc && st == IDLE)          feat[i*F+j] <= '0;
                else if (acc && st == LOAD_KER) feat[i*F+j] <= feat[i*F+j] + prod;
            end
        end
    end

    // ReLU on the current 2x2 block, then signed max or floored average
    always_comb begin
        fb     = FW'(oy) * FW'(2 * F) + FW'(ox) * FW'(2);
        q0     = (!opt_q[0] && feat[fb][OW-1])            ? '0 : feat[fb];
        q1     = (!opt_q[0] && feat[fb+FW'(1)][OW-1])     ? '0 : feat[fb+FW'(1)];
        q2     = (!opt_q[0] && feat[fb+FW'(F)][OW-1])     ? '0 : feat[fb+FW'(F)];
        q3     = (!opt_q[0] && feat[fb+FW'(F+1)][OW-1])   ? '0 : feat[fb+FW'(F+1)];
        m01    = q0 > q1 ? q0 : q1;
        m23    = q2 > q3 ? q2 : q3;
        mx     = m01 > m23 ? m01 : m23;
        sum    = SW'(q0) + SW'(q1) + SW'(q2) + SW'(q3);
        pooled = opt_q[1] ? OW'(sum >>> 2) : mx;
    end
endmodule

// File: tb/tb_cnn_param.sv
// tb_cnn_param: randomized frames on IMG=6 and IMG=8 instances checked cycle by cycle against a behavioural model
module tb_cnn_param;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic iv [2];
    logic signed [7:0] id [2];
    logic [1:0] op [2];
    logic rdy [2];
    logic ov [2];
    logic signed [19:0] od [2];

    cnn_param u6 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(id[0]), .opt(op[0]),
                  .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]));
    cnn_param #(.IMG(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(id[1]), .opt(op[1]),
                  .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]));

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int exp_start [2] = '{-1, -1};
    int first_acc [2];
    int last_acc [2];
    longint exp_v [2][16];
    int pix [64];
    int ker [9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, req);
        end
    endtask

    // outputs must be P*P pooled values starting two cycles after the last weight, idle otherwise
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int w = 0; w < 2; w++) begin
                int pp, k;
                bit act, ev, busy;
                pp   = w ? 9 : 4;
                k    = cyc - exp_start[w];
                act  = exp_start[w] >= 0;
                ev   = act && k >= 0 && k < pp;
                busy = act && k >= -1 && k < pp;
                chk($sformatf("out_valid%0d@%0d", w, cyc), 64'(ov[w]), ev ? 64'sd1 : 64'sd0);
                chk($sformatf("in_ready%0d@%0d", w, cyc), 64'(rdy[w]), busy ? 64'sd0 : 64'sd1);
                if (ev) chk($sformatf("out_data%0d[%0d]", w, k), 64'(od[w]), exp_v[w][k]);
                else    chk($sformatf("out_idle%0d@%0d", w, cyc), 64'(od[w]), 64'sd0);
            end
        end
    end

    task automatic model(input int w, input logic [1:0] o);
        int n, f, p;
        longint fm [6][6];
        longint v [4];
        longint s;
        n = w ? 8 : 6;
        f = n - 2;
        p = f / 2;
        for (int i = 0; i < f; i++)
            for (int j = 0; j < f; j++) begin
                s = 0;
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        s += longint'(pix[(i + ky) * n + j + kx]) * longint'(ker[ky * 3 + kx]);
                fm[i][j] = (!o[0] && s < 0) ? 0 : s;
            end
        for (int by = 0; by < p; by++)
            for (int bx = 0; bx < p; bx++) begin
                v[0] = fm[2*by][2*bx];
                v[1] = fm[2*by][2*bx+1];
                v[2] = fm[2*by+1][2*bx];
                v[3] = fm[2*by+1][2*bx+1];
                if (o[1]) begin
                    s = v[0] + v[1] + v[2] + v[3];
                    s = s >= 0 ? s / 4 : -((3 - s) / 4);
                end else begin
                    s = v[0];
                    for (int t = 1; t < 4; t++) if (v[t] > s) s = v[t];
                end
                exp_v[w][by * p + bx] = s;
            end
    endtask

    task automatic send_beat(input int w, input int d, input logic [1:0] o, input bit gaps, output int acc_cyc);
        int tries = 0;
        acc_cyc = -1;
        while (acc_cyc < 0) begin
            @(posedge clk);
            #1;
            if (tries++ > 300) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout inst %0d got no accept want accept within 300 cycles", w);
                return;
            end
            if (!rdy[w]) begin
                iv[w] = 1;
                id[w] = 8'($urandom);
                op[w] = 2'($urandom);
            end else if (gaps && $urandom_range(0, 3) == 0) begin
                iv[w] = 0;
                id[w] = 8'($urandom);
            end else begin
                iv[w] = 1;
                id[w] = 8'(d);
                op[w] = o;
                @(negedge clk);
                if (rdy[w]) acc_cyc = cyc;
            end
        end
    endtask

    task automatic send_frame(input int w, input logic [1:0] o, input bit gaps, input int nbeats);
        int n, ac;
        n = w ? 8 : 6;
        for (int b = 0; b < nbeats; b++) begin
            send_beat(w, b < n * n ? pix[b] : ker[b - n * n], b == 0 ? o : 2'($urandom), gaps && b > 0, ac);
            if (b == 0) first_acc[w] = ac;
            last_acc[w] = ac;
        end
        if (nbeats == n * n + 9) begin
            model(w, o);
            exp_start[w] = last_acc[w] + 2;
        end
    endtask

    task automatic pin(input string nm, input longint e0, input longint e1, input longint e2, input longint e3);
        chk({nm, "_0"}, exp_v[0][0], e0);
        chk({nm, "_1"}, exp_v[0][1], e1);
        chk({nm, "_2"}, exp_v[0][2], e2);
        chk({nm, "_3"}, exp_v[0][3], e3);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n * n; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < 9; i++) ker[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        int s;
        iv[0] = 0; iv[1] = 0;
        id[0] = 0; id[1] = 0;
        op[0] = 0; op[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < 36; i++) pix[i] = 1;
        for (int i = 0; i < 9; i++) ker[i] = 1;
        send_frame(0, 2'd0, 0, 45);
        pin("ones", 9, 9, 9, 9);

        for (int i = 0; i < 9; i++) ker[i] = -1;
        send_frame(0, 2'd0, 0, 45);
        pin("neg_relu", 0, 0, 0, 0);
        send_frame(0, 2'd1, 0, 45);
        pin("neg_bypass", -9, -9, -9, -9);
        send_frame(0, 2'd3, 0, 45);
        pin("neg_avg", -9, -9, -9, -9);

        for (int i = 0; i < 36; i++) pix[i] = i / 6;
        for (int i = 0; i < 9; i++) ker[i] = i == 4 ? 1 : 0;
        send_frame(0, 2'd0, 0, 45);
        pin("rows_max", 2, 2, 4, 4);
        send_frame(0, 2'd2, 0, 45);
        pin("rows_avg", 1, 1, 3, 3);

        for (int i = 0; i < 36; i++) pix[i] = -128;
        for (int i = 0; i < 9; i++) ker[i] = -128;
        send_frame(0, 2'd0, 0, 45);
        pin("big", 147456, 147456, 147456, 147456);
        send_frame(0, 2'd0, 1, 45);
        pin("big_gaps", 147456, 147456, 147456, 147456);

        for (int i = 0; i < 36; i++) pix[i] = 1;
        for (int i = 0; i < 9; i++) ker[i] = 1;
        send_frame(0, 2'd0, 0, 20);
        @(posedge clk);
        #1 rst_n = 0;
        iv[0] = 0;
        exp_start[0] = -1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        send_frame(0, 2'd0, 0, 45);
        pin("after_reset", 9, 9, 9, 9);
        s = exp_start[0];
        fill_rand(6);
        send_frame(0, 2'($urandom), 1, 45);
        chk("back_to_back_start", 64'(first_acc[0]), 64'(s + 4));

        for (int r = 0; r < 6; r++) begin
            fill_rand(6);
            send_frame(0, 2'($urandom), r[0], 45);
        end
        @(posedge clk);
        #1 iv[0] = 0;

        for (int r = 0; r < 6; r++) begin
            fill_rand(8);
            send_frame(1, r < 4 ? 2'(r) : 2'($urandom), r[0], 73);
        end
        @(posedge clk);
        #1 iv[1] = 0;
        repeat (20) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
